// File: rtl/imem_boot_loader_if.sv
// Byte-stream input and instruction-memory load port of the boot loader.
// The master modport belongs to the byte source; the slave modport belongs to the loader.
interface imem_boot_loader_if #(
    parameter int unsigned ADDR_W = 9
);
    logic              s_valid;
    logic [7:0]        s_data;
    logic              s_ready;
    logic              we0;
    logic [ADDR_W-1:0] wr_addr0;
    logic [31:0]       wr_din0;

    modport master (
        output s_valid,
        output s_data,
        input  s_ready,
        input  we0,
        input  wr_addr0,
        input  wr_din0
    );

    modport slave (
        input  s_valid,
        input  s_data,
        output s_ready,
        output we0,
        output wr_addr0,
        output wr_din0
    );
endinterface

// File: rtl/imem_boot_loader.sv
// Loads instruction memory from a byte stream (16-bit word-count header followed by
// little-endian words), holding the core PC in reset until the load completes.
module imem_boot_loader #(
    parameter int unsigned MAX_WORDS = 128,
    parameter int unsigned ADDR_W    = 9
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                load_req,
    imem_boot_loader_if.slave   bus,
    output logic                resetpc,
    output logic                busy,
    output logic                err,
    output logic [7:0]          word_cnt
);

    localparam int unsigned WIDX_W = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;
    localparam int unsigned CNT_W  = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR0,
        S_HDR1,
        S_DATA,
        S_WRITE,
        S_RUN,
        S_ERR
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [WIDX_W-1:0]   word_idx_q, word_idx_d;
    logic [1:0]          byte_idx_q, byte_idx_d;
    logic [23:0]         word_buf_q, word_buf_d;
    logic [7:0]          word_cnt_q, word_cnt_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [31:0]         wr_din_q, wr_din_d;
    logic                s_ready_q, s_ready_d;
    logic                we0_q, we0_d;
    logic                resetpc_q, resetpc_d;
    logic                busy_q, busy_d;
    logic                err_q, err_d;

    logic                xfer;
    logic [CNT_W-1:0]    hdr_count;
    logic                last_word;

    assign xfer      = bus.s_valid & s_ready_q;
    assign hdr_count = {bus.s_data, count_q[7:0]};
    assign last_word = (CNT_W'(word_idx_q) == (count_q - CNT_W'(1)));

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            count_q    <= '0;
            word_idx_q <= '0;
            byte_idx_q <= '0;
            word_buf_q <= '0;
            word_cnt_q <= '0;
            wr_addr_q  <= '0;
            wr_din_q   <= '0;
            s_ready_q  <= 1'b0;
            we0_q      <= 1'b0;
            resetpc_q  <= 1'b0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            word_idx_q <= word_idx_d;
            byte_idx_q <= byte_idx_d;
            word_buf_q <= word_buf_d;
            word_cnt_q <= word_cnt_d;
            wr_addr_q  <= wr_addr_d;
            wr_din_q   <= wr_din_d;
            s_ready_q  <= s_ready_d;
            we0_q      <= we0_d;
            resetpc_q  <= resetpc_d;
            busy_q     <= busy_d;
            err_q      <= err_d;
        end
    end

    // Next-state, datapath and Moore output decode of the next state
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        word_idx_d = word_idx_q;
        byte_idx_d = byte_idx_q;
        word_buf_d = word_buf_q;
        word_cnt_d = word_cnt_q;
        wr_addr_d  = wr_addr_q;
        wr_din_d   = wr_din_q;

        if (load_req) begin
            // Restart wins over any byte presented this cycle; partial words are dropped.
            state_d    = S_HDR0;
            count_d    = '0;
            word_idx_d = '0;
            byte_idx_d = '0;
            word_buf_d = '0;
            word_cnt_d = '0;
        end else begin
            case (state_q)
                S_HDR0: begin
                    if (xfer) begin
                        count_d[7:0] = bus.s_data;
                        state_d      = S_HDR1;
                    end
                end
                S_HDR1: begin
                    if (xfer) begin
                        count_d    = hdr_count;
                        word_idx_d = '0;
                        byte_idx_d = '0;
                        if (hdr_count == '0) begin
                            state_d = S_RUN;
                        end else if (hdr_count > CNT_W'(MAX_WORDS)) begin
                            state_d = S_ERR;
                        end else begin
                            state_d = S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (xfer) begin
                        byte_idx_d = byte_idx_q + 2'd1;
                        case (byte_idx_q)
                            2'd0: word_buf_d[7:0]   = bus.s_data;
                            2'd1: word_buf_d[15:8]  = bus.s_data;
                            2'd2: word_buf_d[23:16] = bus.s_data;
                            default: begin
                                wr_addr_d = ADDR_W'({word_idx_q, 2'b00});
                                wr_din_d  = {bus.s_data, word_buf_q};
                                state_d   = S_WRITE;
                            end
                        endcase
                    end
                end
                S_WRITE: begin
                    word_cnt_d = word_cnt_q + 8'd1;
                    byte_idx_d = '0;
                    if (last_word) begin
                        state_d = S_RUN;
                    end else begin
                        word_idx_d = word_idx_q + WIDX_W'(1);
                        state_d    = S_DATA;
                    end
                end
                S_IDLE, S_RUN, S_ERR: begin
                    state_d = state_q;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        s_ready_d = (state_d == S_HDR0) || (state_d == S_HDR1) || (state_d == S_DATA);
        we0_d     = (state_d == S_WRITE);
        resetpc_d = (state_d == S_RUN);
        err_d     = (state_d == S_ERR);
        busy_d    = (state_d == S_HDR0) || (state_d == S_HDR1) ||
                    (state_d == S_DATA) || (state_d == S_WRITE);
    end

    assign bus.s_ready  = s_ready_q;
    assign bus.we0      = we0_q;
    assign bus.wr_addr0 = wr_addr_q;
    assign bus.wr_din0  = wr_din_q;
    assign resetpc      = resetpc_q;
    assign busy         = busy_q;
    assign err          = err_q;
    assign word_cnt     = word_cnt_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Randomized scoreboard bench for imem_boot_loader: stimulus queues expected memory
// writes, a negedge monitor pops and compares each we0 pulse.
module tb_imem_boot_loader;

    localparam int unsigned MAX_WORDS = 128;
    localparam int unsigned ADDR_W    = 9;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       din;
    } wr_t;

    logic        clk;
    logic        reset;
    logic        load_req;
    logic        resetpc;
    logic        busy;
    logic        err;
    logic [7:0]  word_cnt;

    int          checks;
    int          errors;
    int          cyc;
    int          last_we_cyc;
    wr_t         exp_q[$];
    logic [31:0] wq[$];

    imem_boot_loader_if #(.ADDR_W(ADDR_W)) bus ();

    imem_boot_loader #(
        .MAX_WORDS(MAX_WORDS),
        .ADDR_W   (ADDR_W)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .load_req(load_req),
        .bus     (bus),
        .resetpc (resetpc),
        .busy    (busy),
        .err     (err),
        .word_cnt(word_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard monitor: every write pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        wr_t e;
        if (!reset && bus.we0) begin
            last_we_cyc = cyc;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: addr=0x%0h din=0x%0h with nothing expected",
                         bus.wr_addr0, bus.wr_din0);
            end else begin
                e = exp_q.pop_front();
                check("wr_addr0", 64'(bus.wr_addr0), 64'(e.addr));
                check("wr_din0", 64'(bus.wr_din0), 64'(e.din));
            end
        end
    end

    task automatic pulse_load();
        load_req = 1'b1;
        @(posedge clk); #1;
        load_req = 1'b0;
    endtask

    // Presents one byte and returns just after the edge on which it was accepted.
    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        bus.s_valid = 1'b1;
        bus.s_data  = b;
        while (!bus.s_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!bus.s_ready) begin
            checks++;
            errors++;
            $display("FAIL s_ready_timeout: s_ready=0 for 50 cycles, required 1");
        end
        @(posedge clk); #1;
    endtask

    task automatic gap(input int mode);
        int k;
        k = (mode == 1) ? 1 : (mode == 2) ? int'($urandom_range(0, 2)) : 0;
        for (int i = 0; i < k; i++) begin
            bus.s_valid = 1'b0;
            bus.s_data  = 8'($urandom);
            @(posedge clk); #1;
        end
    endtask

    // Loads n words from wq; gap_mode 0=none, 1=alternate idle, 2=random idles.
    // abort_at >= 0 restarts via load_req just before that data byte index.
    task automatic do_load(input int n, input int gap_mode, input int abort_at);
        int          first_cyc;
        int          waited;
        logic [15:0] hdr;
        logic [31:0] w;
        hdr = 16'(n);
        pulse_load();
        @(negedge clk);
        check("start_resetpc", 64'(resetpc), 64'(0));
        check("start_err", 64'(err), 64'(0));
        check("start_word_cnt", 64'(word_cnt), 64'(0));
        check("start_busy", 64'(busy), 64'(1));

        send_byte(hdr[7:0]);
        first_cyc = cyc;
        gap(gap_mode);
        send_byte(hdr[15:8]);

        if (n > int'(MAX_WORDS)) begin
            bus.s_valid = 1'b1;
            @(negedge clk);
            check("err_set", 64'(err), 64'(1));
            check("err_resetpc", 64'(resetpc), 64'(0));
            check("err_busy", 64'(busy), 64'(0));
            for (int i = 0; i < 4; i++) begin
                check("err_s_ready", 64'(bus.s_ready), 64'(0));
                @(negedge clk);
            end
            bus.s_valid = 1'b0;
            return;
        end
        if (n > 0) gap(gap_mode);

        for (int i = 0; i < n; i++) begin
            w = wq[i];
            for (int b = 0; b < 4; b++) begin
                if (4 * i + b == abort_at) begin
                    bus.s_data  = 8'hA5;
                    bus.s_valid = 1'b1;
                    pulse_load();
                    bus.s_valid = 1'b0;
                    @(negedge clk);
                    check("abort_busy", 64'(busy), 64'(1));
                    check("abort_word_cnt", 64'(word_cnt), 64'(0));
                    check("abort_resetpc", 64'(resetpc), 64'(0));
                    check("abort_s_ready", 64'(bus.s_ready), 64'(1));
                    wq.delete();
                    return;
                end
                send_byte(w[8*b +: 8]);
                if (b == 3) exp_q.push_back('{addr: ADDR_W'(4 * i), din: w});
                if (4 * i + b != 4 * n - 1) gap(gap_mode);
            end
        end
        bus.s_valid = 1'b0;

        waited = 0;
        @(negedge clk);
        while (!resetpc && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check("resetpc_rise", 64'(resetpc), 64'(1));
        if (n > 0) check("run_after_last_write", 64'(cyc - last_we_cyc), 64'(1));
        if (gap_mode == 0) check("load_latency", 64'(cyc - first_cyc + 1), 64'(2 + 5 * n));
        check("end_word_cnt", 64'(word_cnt), 64'(n));
        check("end_busy", 64'(busy), 64'(0));
        check("end_err", 64'(err), 64'(0));
        check("end_s_ready", 64'(bus.s_ready), 64'(0));
        check("pending_writes", 64'(exp_q.size()), 64'(0));
        wq.delete();
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_s_ready"}, 64'(bus.s_ready), 64'(0));
        check({tag, "_we0"}, 64'(bus.we0), 64'(0));
        check({tag, "_wr_addr0"}, 64'(bus.wr_addr0), 64'(0));
        check({tag, "_wr_din0"}, 64'(bus.wr_din0), 64'(0));
        check({tag, "_resetpc"}, 64'(resetpc), 64'(0));
        check({tag, "_busy"}, 64'(busy), 64'(0));
        check({tag, "_err"}, 64'(err), 64'(0));
        check({tag, "_word_cnt"}, 64'(word_cnt), 64'(0));
    endtask

    initial begin
        int n;
        int gm;
        int ab;
        checks      = 0;
        errors      = 0;
        cyc         = 0;
        last_we_cyc = -100;
        reset       = 1'b1;
        load_req    = 1'b0;
        bus.s_valid = 1'b0;
        bus.s_data  = 8'h00;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check_reset_state("por");

        // IDLE ignores bytes until load_req
        bus.s_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("idle_s_ready", 64'(bus.s_ready), 64'(0));
        end
        bus.s_valid = 1'b0;
        @(posedge clk); #1;

        wq = '{32'h00500093, 32'h00A00113, 32'h002081B3};
        do_load(3, 0, -1);

        do_load(0, 0, -1);

        do_load(129, 0, -1);
        wq.push_back($urandom);
        do_load(1, 0, -1);

        wq.push_back($urandom);
        wq.push_back($urandom);
        do_load(2, 1, -1);

        wq.push_back(32'hDEADBEEF);
        do_load(1, 0, -1);

        // Synchronous reset in the middle of the first data word
        pulse_load();
        send_byte(8'h02);
        send_byte(8'h00);
        send_byte(8'h11);
        send_byte(8'h22);
        reset       = 1'b1;
        bus.s_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check_reset_state("midload_reset");
        bus.s_valid = 1'b1;
        bus.s_data  = 8'h33;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("post_reset_idle_s_ready", 64'(bus.s_ready), 64'(0));
        end
        bus.s_valid = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < int'(MAX_WORDS); i++) wq.push_back($urandom);
        do_load(int'(MAX_WORDS), 0, -1);

        for (int it = 0; it < 12; it++) begin
            n  = int'($urandom_range(1, 6));
            gm = int'($urandom_range(0, 2));
            ab = -1;
            if ($urandom_range(0, 3) == 0) ab = int'($urandom_range(1, 4 * n - 1));
            for (int i = 0; i < n; i++) wq.push_back($urandom);
            do_load(n, gm, ab);
        end

        wq.push_back($urandom);
        do_load(1, 2, -1);

        repeat (3) @(negedge clk);
        check("final_pending_writes", 64'(exp_q.size()), 64'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
